mod3_serial_scheduler: RTL and testbench

MOD3_SERIAL_SCHEDULER -- requirements
Module: mod3_serial_scheduler

---
 rtl/mod3_serial_scheduler.sv | 126 ++++++++++++
 tb/tb_mod3_serial_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mod3_serial_scheduler.sv
// Two-requester round-robin scheduler feeding a bit-serial divisible-by-3 checker.
// Optional MOD3_RESIDUE_OUT_EN adds the res_rem final-residue port.
module mod3_serial_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_div3,
  output logic             res_id,
`ifdef MOD3_RESIDUE_OUT_EN
  output logic [1:0]       res_rem,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [1:0]       residue;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             gnt;
  logic             accept;
  logic [1:0]       res_next;

  function automatic logic [1:0] mod3_step(
    input logic [1:0] r,
    input logic       b
  );
    logic [1:0] n;
    n = 2'd0;
    unique case ({r, b})
      3'b000:  n = 2'd0;
      3'b001:  n = 2'd1;
      3'b010:  n = 2'd2;
      3'b011:  n = 2'd0;
      3'b100:  n = 2'd1;
      3'b101:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // last holds the most recently served id; on contention the other wins
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid)
      gnt = ~last;
    else
      gnt = req1_valid;
  end

  assign accept     = !reset && (state == IDLE)
                    && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;
  assign res_next   = mod3_step(residue, sreg[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      residue   <= 2'd0;
      cnt       <= '0;
      last      <= 1'b1;
      res_valid <= 1'b0;
      res_div3  <= 1'b0;
      res_id    <= 1'b0;
      busy      <= 1'b0;
`ifdef MOD3_RESIDUE_OUT_EN
      res_rem   <= 2'd0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sreg    <= gnt ? req1_data : req0_data;
            res_id  <= gnt;
            residue <= 2'd0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          residue <= res_next;
          sreg    <= sreg << 1;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_valid <= 1'b1;
            res_div3  <= (res_next == 2'd0);
`ifdef MOD3_RESIDUE_OUT_EN
            res_rem   <= res_next;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            last      <= res_id;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod3_serial_scheduler.sv
// Table-driven scoreboard bench for mod3_serial_scheduler at WIDTH=8.
// Compile with MOD3_RESIDUE_OUT_EN defined to also check res_rem.
module tb_mod3_serial_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = '0;
  logic       req1_ready;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_div3;
  logic       res_id;
  logic       busy;
`ifdef MOD3_RESIDUE_OUT_EN
  logic [1:0] res_rem;
`endif

  int checks = 0;
  int errors = 0;

  mod3_serial_scheduler #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_div3   (res_div3),
    .res_id     (res_id),
`ifdef MOD3_RESIDUE_OUT_EN
    .res_rem    (res_rem),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       id;
    logic       div3;
    logic [1:0] rem;
    int         hold;
  } vec_t;

  typedef struct {
    logic       id;
    logic       div3;
    logic [1:0] rem;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int   lat;
    exp_t e;
    logic s0, s1;
    req0_valid = v.v0;
    req0_data  = v.d0;
    req1_valid = v.v1;
    req1_data  = v.d1;
    res_ready  = 1'b0;
    #1;
    chk("grant0", req0_ready, int'(v.id == 1'b0));
    chk("grant1", req1_ready, int'(v.id == 1'b1));
    sb.push_back('{v.id, v.div3, v.rem});
    @(posedge clk); #1;
    if (v.id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    chk("busy_shift", busy, 1);
    chk("ready_shift", int'(req0_ready | req1_ready), 0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 8);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      e = '{1'b0, 1'b0, 2'd0};
    end else begin
      e = sb.pop_front();
    end
    chk("res_id", res_id, e.id);
    chk("res_div3", res_div3, e.div3);
`ifdef MOD3_RESIDUE_OUT_EN
    chk("res_rem", res_rem, e.rem);
`endif
    if (v.hold > 0) begin
      s0 = req0_valid;
      s1 = req1_valid;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
        chk("hold_valid", res_valid, 1);
        chk("hold_id", res_id, e.id);
        chk("hold_div3", res_div3, e.div3);
        chk("hold_ready", int'(req0_ready | req1_ready), 0);
      end
      req0_valid = s0;
      req1_valid = s1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post_valid", res_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    vec_t v;
    tbl[0] = '{1'b1, 8'd0,   1'b0, 8'd0, 1'b0, 1'b1, 2'd0, 0};
    tbl[1] = '{1'b0, 8'd0,   1'b1, 8'd255, 1'b1, 1'b1, 2'd0, 0};
    tbl[2] = '{1'b0, 8'd0,   1'b1, 8'd7, 1'b1, 1'b0, 2'd1, 0};
    tbl[3] = '{1'b1, 8'd128, 1'b0, 8'd0, 1'b0, 1'b0, 2'd2, 0};
    tbl[4] = '{1'b1, 8'd255, 1'b0, 8'd0, 1'b0, 1'b1, 2'd0, 5};
    tbl[5] = '{1'b0, 8'd0,   1'b1, 8'd1, 1'b1, 1'b0, 2'd1, 0};
    tbl[6] = '{1'b1, 8'd3,   1'b0, 8'd0, 1'b0, 1'b1, 2'd0, 0};

    do_reset();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_div3", res_div3, 0);
`ifdef MOD3_RESIDUE_OUT_EN
    chk("rst_res_rem", res_rem, 0);
`endif

    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    // round-robin under contention, starting fresh from reset
    do_reset();
    v = '{1'b1, 8'd9, 1'b1, 8'd10, 1'b0, 1'b1, 2'd0, 0};
    run_op(v);
    v = '{1'b1, 8'd9, 1'b1, 8'd10, 1'b1, 1'b0, 2'd1, 3};
    run_op(v);
    v = '{1'b1, 8'd9, 1'b1, 8'd10, 1'b0, 1'b1, 2'd0, 0};
    run_op(v);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // reset during the 4th shift cycle aborts the operation
    req0_valid = 1'b1;
    req0_data  = 8'd5;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen = seen | int'(res_valid);
    end
    chk("abort_no_result", seen, 0);
    v = '{1'b1, 8'd3, 1'b0, 8'd0, 1'b0, 1'b1, 2'd0, 0};
    run_op(v);

    // valid that drops before the edge leaves the block idle
    req0_valid = 1'b1;
    req0_data  = 8'd4;
    #2;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("drop_busy", busy, 0);
    chk("drop_valid", res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
